// File: rtl/gci_std_display_vram_if_responder.sv
// ============================================================================
// gci_std_display_vram_if_responder: grants display VRAM sessions, forwards
// accesses to memory and returns read data through a credit-protected FIFO.
// Rev 1.0
// ============================================================================
`default_nettype none

module gci_std_display_vram_if_responder #(
    parameter int P_MEM_ADDR_N      = 23,
    parameter int P_RD_FIFO_DEPTH   = 4,
    parameter int P_RD_FIFO_DEPTH_N = 2
) (
    input  logic                    iCLOCK,
    input  logic                    inRESET,
    // Session handshake
    input  logic                    iIF_REQ,
    output logic                    oIF_ACK,
    input  logic                    iIF_FINISH,
    output logic                    oIF_BREAK,
    // Command channel
    output logic                    oIF_BUSY,
    input  logic                    iIF_ENA,
    input  logic                    iIF_RW,
    input  logic [P_MEM_ADDR_N-1:0] iIF_ADDR,
    input  logic [7:0]              iIF_R,
    input  logic [7:0]              iIF_G,
    input  logic [7:0]              iIF_B,
    // Read return channel
    output logic                    oIF_VALID,
    input  logic                    iIF_BUSY,
    output logic [31:0]             oIF_DATA,
    // Priority client
    input  logic                    iBREAK_REQ,
    // Memory command/response port
    output logic                    oMEM_VALID,
    input  logic                    iMEM_BUSY,
    output logic                    oMEM_RW,
    output logic [P_MEM_ADDR_N-1:0] oMEM_ADDR,
    output logic [31:0]             oMEM_DATA,
    input  logic                    iMEM_VALID,
    input  logic [31:0]             iMEM_DATA
);

    localparam int CW = P_RD_FIFO_DEPTH_N + 1;
    localparam logic [CW:0]                  C_DEPTH   = (CW+1)'(P_RD_FIFO_DEPTH);
    localparam logic [CW-1:0]                C_CNT_ONE = CW'(1);
    localparam logic [P_RD_FIFO_DEPTH_N-1:0] C_PTR_ONE = P_RD_FIFO_DEPTH_N'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACK   = 3'd1,
        ST_WORK  = 3'd2,
        ST_BREAK = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    state_t                       state_q;
    logic                         ack_q;
    logic                         break_q;
    logic [CW-1:0]                outstanding_q;
    logic [CW-1:0]                outstanding_d;
    logic [CW-1:0]                fifo_count_q;
    logic [CW-1:0]                fifo_count_d;
    logic [P_RD_FIFO_DEPTH_N-1:0] wr_ptr_q;
    logic [P_RD_FIFO_DEPTH_N-1:0] rd_ptr_q;
    logic [31:0]                  fifo_mem_q [P_RD_FIFO_DEPTH];

    logic [CW:0] credit_used;
    logic        cmd_accept;
    logic        rd_accept;
    logic        rsp_push;
    logic        rsp_pop;

    // Reads in flight plus words already buffered may never exceed the FIFO.
    assign credit_used = {1'b0, outstanding_q} + {1'b0, fifo_count_q};
    assign oIF_BUSY    = (state_q != ST_WORK) || iMEM_BUSY || (credit_used >= C_DEPTH);

    assign cmd_accept = iIF_ENA && !oIF_BUSY;
    assign rd_accept  = cmd_accept && !iIF_RW;
    assign rsp_push   = iMEM_VALID && (outstanding_q != '0);
    assign rsp_pop    = oIF_VALID && !iIF_BUSY;

    assign oMEM_VALID = cmd_accept;
    assign oMEM_RW    = iIF_RW;
    assign oMEM_ADDR  = iIF_ADDR;
    assign oMEM_DATA  = {8'h00, iIF_R, iIF_G, iIF_B};

    assign oIF_VALID = (fifo_count_q != '0);
    assign oIF_DATA  = fifo_mem_q[rd_ptr_q];
    assign oIF_ACK   = ack_q;
    assign oIF_BREAK = break_q;

    always_comb begin
        outstanding_d = outstanding_q;
        case ({rd_accept, rsp_push})
            2'b10:   outstanding_d = outstanding_q + C_CNT_ONE;
            2'b01:   outstanding_d = outstanding_q - C_CNT_ONE;
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_comb begin
        fifo_count_d = fifo_count_q;
        case ({rsp_push, rsp_pop})
            2'b10:   fifo_count_d = fifo_count_q + C_CNT_ONE;
            2'b01:   fifo_count_d = fifo_count_q - C_CNT_ONE;
            default: fifo_count_d = fifo_count_q;
        endcase
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            outstanding_q <= '0;
            fifo_count_q  <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            fifo_count_q  <= fifo_count_d;
            if (rsp_push) begin
                wr_ptr_q <= wr_ptr_q + C_PTR_ONE;
            end
            if (rsp_pop) begin
                rd_ptr_q <= rd_ptr_q + C_PTR_ONE;
            end
        end
    end

    // Storage needs no reset: contents are only visible while count is non-zero.
    always_ff @(posedge iCLOCK) begin
        if (rsp_push) begin
            fifo_mem_q[wr_ptr_q] <= iMEM_DATA;
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            break_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (iIF_REQ && !iBREAK_REQ) begin
                        state_q <= ST_ACK;
                        ack_q   <= 1'b1;
                    end
                end
                ST_ACK: begin
                    state_q <= ST_WORK;
                    ack_q   <= 1'b0;
                end
                ST_WORK: begin
                    if (iIF_FINISH) begin
                        state_q <= ST_DRAIN;
                    end else if (iBREAK_REQ) begin
                        state_q <= ST_BREAK;
                        break_q <= 1'b1;
                    end
                end
                ST_BREAK: begin
                    if (iIF_FINISH) begin
                        state_q <= ST_DRAIN;
                        break_q <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if ((outstanding_q == '0) && (fifo_count_q == '0)) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ack_q   <= 1'b0;
                    break_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_gci_std_display_vram_if_responder.sv
// ============================================================================
// tb_gci_std_display_vram_if_responder: directed and random stimulus checked
// against a queue-based session/credit model. Rev 1.0
// ============================================================================
`default_nettype none

module tb_gci_std_display_vram_if_responder;

    localparam int AW    = 23;
    localparam int DEPTH = 4;

    localparam int M_IDLE  = 0;
    localparam int M_ACK   = 1;
    localparam int M_WORK  = 2;
    localparam int M_BREAK = 3;
    localparam int M_DRAIN = 4;

    logic          iCLOCK = 1'b0;
    logic          inRESET;
    logic          iIF_REQ, oIF_ACK, iIF_FINISH, oIF_BREAK, oIF_BUSY;
    logic          iIF_ENA, iIF_RW;
    logic [AW-1:0] iIF_ADDR;
    logic [7:0]    iIF_R, iIF_G, iIF_B;
    logic          oIF_VALID, iIF_BUSY;
    logic [31:0]   oIF_DATA;
    logic          iBREAK_REQ;
    logic          oMEM_VALID, iMEM_BUSY, oMEM_RW;
    logic [AW-1:0] oMEM_ADDR;
    logic [31:0]   oMEM_DATA;
    logic          iMEM_VALID;
    logic [31:0]   iMEM_DATA;

    gci_std_display_vram_if_responder #(
        .P_MEM_ADDR_N     (AW),
        .P_RD_FIFO_DEPTH  (DEPTH),
        .P_RD_FIFO_DEPTH_N(2)
    ) dut (
        .iCLOCK    (iCLOCK),
        .inRESET   (inRESET),
        .iIF_REQ   (iIF_REQ),
        .oIF_ACK   (oIF_ACK),
        .iIF_FINISH(iIF_FINISH),
        .oIF_BREAK (oIF_BREAK),
        .oIF_BUSY  (oIF_BUSY),
        .iIF_ENA   (iIF_ENA),
        .iIF_RW    (iIF_RW),
        .iIF_ADDR  (iIF_ADDR),
        .iIF_R     (iIF_R),
        .iIF_G     (iIF_G),
        .iIF_B     (iIF_B),
        .oIF_VALID (oIF_VALID),
        .iIF_BUSY  (iIF_BUSY),
        .oIF_DATA  (oIF_DATA),
        .iBREAK_REQ(iBREAK_REQ),
        .oMEM_VALID(oMEM_VALID),
        .iMEM_BUSY (iMEM_BUSY),
        .oMEM_RW   (oMEM_RW),
        .oMEM_ADDR (oMEM_ADDR),
        .oMEM_DATA (oMEM_DATA),
        .iMEM_VALID(iMEM_VALID),
        .iMEM_DATA (iMEM_DATA)
    );

    always #5 iCLOCK = ~iCLOCK;

    typedef struct {
        logic [31:0] data;
        int          due;
    } rsp_t;

    // Model: reads the memory still owes (pend), responses orphaned by a reset
    // (stale), and words waiting for the requester (rfifo).
    rsp_t        pend[$];
    rsp_t        stale[$];
    logic [31:0] rfifo[$];
    int          mstate;
    int          cyc;
    int          lat;
    int          last_due;
    int          tests;
    int          fails;
    logic        last_acc;
    logic        obs_memvalid;
    logic        obs_ifvalid;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        return ({9'h000, a} * 32'h9E3779B1) ^ 32'h13579BDF;
    endfunction

    task automatic step(input logic req, input logic fin, input logic ena, input logic rw,
                        input logic [AW-1:0] addr, input logic [23:0] rgb,
                        input logic ifb, input logic brk, input logic mb);
        logic        mv;
        logic        from_pend;
        logic [31:0] md;
        logic        exp_busy;
        logic        acc;
        logic        drained;
        rsp_t        r;
        @(negedge iCLOCK);
        iIF_REQ    = req;
        iIF_FINISH = fin;
        iIF_ENA    = ena;
        iIF_RW     = rw;
        iIF_ADDR   = addr;
        {iIF_R, iIF_G, iIF_B} = rgb;
        iIF_BUSY   = ifb;
        iBREAK_REQ = brk;
        iMEM_BUSY  = mb;
        mv = 1'b0;
        from_pend = 1'b0;
        md = 32'h0;
        if (pend.size() > 0) begin
            if (pend[0].due <= cyc) begin
                mv = 1'b1;
                from_pend = 1'b1;
                md = pend[0].data;
            end
        end else if (stale.size() > 0) begin
            if (stale[0].due <= cyc) begin
                mv = 1'b1;
                md = stale[0].data;
            end
        end
        iMEM_VALID = mv;
        iMEM_DATA  = md;
        #1;
        exp_busy = (mstate != M_WORK) || mb || ((pend.size() + rfifo.size()) >= DEPTH);
        acc = ena && !exp_busy;
        check_eq("if_busy", oIF_BUSY, exp_busy);
        check_eq("if_ack", oIF_ACK, mstate == M_ACK);
        check_eq("if_break", oIF_BREAK, mstate == M_BREAK);
        check_eq("mem_valid", oMEM_VALID, acc);
        if (acc) begin
            check_eq("mem_rw", oMEM_RW, rw);
            check_eq("mem_addr", oMEM_ADDR, addr);
            check_eq("mem_data", oMEM_DATA, {8'h00, rgb});
        end
        check_eq("if_valid", oIF_VALID, rfifo.size() != 0);
        if (rfifo.size() != 0) begin
            check_eq("if_data", oIF_DATA, rfifo[0]);
        end
        last_acc     = acc;
        obs_memvalid = oMEM_VALID;
        obs_ifvalid  = oIF_VALID;
        @(posedge iCLOCK);
        cyc++;
        drained = (pend.size() == 0) && (rfifo.size() == 0);
        if (rfifo.size() > 0 && !ifb) begin
            void'(rfifo.pop_front());
        end
        if (mv) begin
            if (from_pend) begin
                r = pend.pop_front();
                rfifo.push_back(r.data);
            end else begin
                void'(stale.pop_front());
            end
        end
        if (acc && !rw) begin
            r.data = mem_word(addr);
            r.due  = (cyc + lat > last_due) ? cyc + lat : last_due;
            last_due = r.due;
            pend.push_back(r);
        end
        case (mstate)
            M_IDLE:  if (req && !brk) mstate = M_ACK;
            M_ACK:   mstate = M_WORK;
            M_WORK:  if (fin) mstate = M_DRAIN; else if (brk) mstate = M_BREAK;
            M_BREAK: if (fin) mstate = M_DRAIN;
            M_DRAIN: if (drained) mstate = M_IDLE;
            default: mstate = M_IDLE;
        endcase
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0, '0, 0, 0, 0);
    endtask

    task automatic open_session();
        step(1, 0, 0, 0, '0, '0, 0, 0, 0);
        step(0, 0, 0, 0, '0, '0, 0, 0, 0);
    endtask

    task automatic close_session();
        step(0, 1, 0, 0, '0, '0, 0, 0, 0);
        nop(40);
    endtask

    task automatic do_reset();
        rsp_t r;
        @(negedge iCLOCK);
        iIF_REQ = 0; iIF_FINISH = 0; iIF_ENA = 0; iIF_RW = 0; iIF_ADDR = '0;
        iIF_R = 0; iIF_G = 0; iIF_B = 0; iIF_BUSY = 0; iBREAK_REQ = 0;
        iMEM_BUSY = 0; iMEM_VALID = 0; iMEM_DATA = '0;
        #2;
        inRESET = 1'b0;
        #1;
        check_eq("rst_ack", oIF_ACK, 1'b0);
        check_eq("rst_break", oIF_BREAK, 1'b0);
        check_eq("rst_busy", oIF_BUSY, 1'b1);
        check_eq("rst_valid", oIF_VALID, 1'b0);
        check_eq("rst_mem_valid", oMEM_VALID, 1'b0);
        while (pend.size() > 0) begin
            r = pend.pop_front();
            stale.push_back(r);
        end
        rfifo.delete();
        mstate = M_IDLE;
        repeat (2) begin
            @(posedge iCLOCK);
            cyc++;
        end
        @(negedge iCLOCK);
        inRESET = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int n_acc;
        int n_valid;
        tests = 0; fails = 0; cyc = 0; lat = 2; last_due = 0; mstate = M_IDLE;
        inRESET = 1'b1;
        do_reset();
        nop(2);

        // Basic write
        open_session();
        step(0, 0, 1, 1, 23'h000010, 24'h112233, 0, 0, 0);
        check_eq("wr_forwarded", obs_memvalid, 1'b1);
        close_session();

        // Read credit: six reads, long memory latency
        lat = 10;
        open_session();
        k = 0; n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 1, 0, 23'h100 + 23'(k), '0, 0, 0, 0);
            if (obs_memvalid) n_acc++;
            if (last_acc) k++;
        end
        check_eq("credit_first_burst", n_acc, 4);
        for (int i = 0; i < 80 && k < 6; i++) begin
            step(0, 0, 1, 0, 23'h100 + 23'(k), '0, 0, 0, 0);
            if (last_acc) k++;
        end
        check_eq("credit_all_issued", k, 6);
        close_session();

        // Return backpressure
        lat = 3;
        open_session();
        k = 0;
        for (int i = 0; i < 20 && k < 4; i++) begin
            step(0, 0, 1, 0, 23'h2000 + 23'(k), '0, 1, 0, 0);
            if (last_acc) k++;
        end
        for (int i = 0; i < 12; i++) step(0, 0, 0, 0, '0, '0, 1, 0, 0);
        n_valid = 0;
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, 0, '0, '0, 0, 0, 0);
            if (obs_ifvalid) n_valid++;
        end
        check_eq("bp_delivered", n_valid, 4);
        close_session();

        // Break during a session with reads in flight
        lat = 6;
        open_session();
        step(0, 0, 1, 0, 23'h3000, '0, 0, 0, 0);
        step(0, 0, 1, 0, 23'h3001, '0, 0, 0, 0);
        step(0, 0, 0, 0, '0, '0, 0, 1, 0);
        step(0, 0, 1, 0, 23'h3002, '0, 0, 0, 0);
        check_eq("break_blocks_ena", obs_memvalid, 1'b0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 23'h3003, 24'hABCDEF, 0, 0, 0);
        close_session();
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, '0, '0, 0, 1, 0);
        nop(2);

        // FINISH and BREAK together; read accept overlapping a response
        lat = 1;
        open_session();
        for (int i = 0; i < 6; i++) step(0, 0, 1, 0, 23'h4000 + 23'(i), '0, 0, 0, 0);
        step(0, 1, 0, 0, '0, '0, 0, 1, 0);
        nop(6);

        // Reset mid-session with two reads outstanding
        lat = 20;
        open_session();
        step(0, 0, 1, 0, 23'h5000, '0, 0, 0, 0);
        step(0, 0, 1, 0, 23'h5001, '0, 0, 0, 0);
        do_reset();
        last_due = 0;
        nop(30);
        check_eq("stale_drained", stale.size(), 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            lat = $urandom_range(1, 8);
            step(($urandom % 4) == 0, ($urandom % 12) == 0, $urandom % 2, $urandom % 2,
                 AW'($urandom), 24'($urandom), ($urandom % 3) == 0,
                 ($urandom % 10) == 0, ($urandom % 4) == 0);
        end
        close_session();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
